// File: rtl/display_pkg.sv
// Shared constants and helpers for the four-digit multiplexed hex display scanner.
package display_pkg;

    localparam int DIGITS           = 4;
    localparam int NIBBLE_W         = 4;
    localparam int IDX_W            = 2;
    localparam int VALUE_W          = DIGITS * NIBBLE_W;
    localparam int TICK_DIV_DEFAULT = 100000;

    localparam logic [DIGITS-1:0] ENABLE_OFF = 4'b1111;

    function automatic logic [NIBBLE_W-1:0] nibble_sel(input logic [VALUE_W-1:0] d,
                                                        input logic [IDX_W-1:0]   i);
        return d[{i, 2'b00} +: NIBBLE_W];
    endfunction

    // A digit is a leading zero when it and every more-significant digit are zero.
    function automatic logic is_blanked(input logic [VALUE_W-1:0] d,
                                        input logic [IDX_W-1:0]   i,
                                        input logic               en);
        if (!en || i == '0) return 1'b0;
        return (d >> {i, 2'b00}) == '0;
    endfunction

endpackage

// File: rtl/scan_tick.sv
// Prescaler: asserts tick for one cycle out of every TICK_DIV clk cycles.
module scan_tick
    import display_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int               CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] tick_cnt_q;
    logic [CNT_W-1:0] tick_cnt_d;

    assign tick = (tick_cnt_q == CNT_MAX);

    always_comb begin
        tick_cnt_d = tick_cnt_q + CNT_W'(1);
        if (tick) tick_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_cnt_q <= '0;
        else        tick_cnt_q <= tick_cnt_d;
    end

endmodule

// File: rtl/display_scan.sv
// Four-digit scanner: double-buffered value, frame-aligned commit, leading-zero blanking.
module display_scan
    import display_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [VALUE_W-1:0]  value,
    input  logic                load,
    input  logic                blank_lz,
    output logic [NIBBLE_W-1:0] digit_nibble,
    output logic [DIGITS-1:0]   seven_enable,
    output logic                frame_done
);

    logic tick;
    logic wrap;

    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [VALUE_W-1:0]  disp_q, disp_d;
    logic [VALUE_W-1:0]  pend_q, pend_d;
    logic                pend_v_q, pend_v_d;
    logic [NIBBLE_W-1:0] digit_nibble_q, digit_nibble_d;
    logic [DIGITS-1:0]   seven_enable_q, seven_enable_d;
    logic                frame_done_q, frame_done_d;

    scan_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign wrap = tick && (idx_q == IDX_W'(DIGITS - 1));

    always_comb begin
        idx_d          = idx_q;
        disp_d         = disp_q;
        pend_d         = pend_q;
        pend_v_d       = pend_v_q;
        digit_nibble_d = digit_nibble_q;
        seven_enable_d = seven_enable_q;
        frame_done_d   = 1'b0;

        // The shadow only changes on the frame wrap, so a frame never mixes two values.
        if (wrap) begin
            if (load)          disp_d = value;
            else if (pend_v_q) disp_d = pend_q;
            pend_v_d = 1'b0;
        end else if (load) begin
            pend_d   = value;
            pend_v_d = 1'b1;
        end

        // Outputs are built from the next idx/disp so the new slot shows up on the tick edge.
        if (tick) begin
            idx_d          = idx_q + IDX_W'(1);
            digit_nibble_d = nibble_sel(disp_d, idx_d);
            seven_enable_d = is_blanked(disp_d, idx_d, blank_lz) ? ENABLE_OFF
                                                                  : ~(4'b0001 << idx_d);
            frame_done_d   = wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q          <= '0;
            disp_q         <= '0;
            pend_q         <= '0;
            pend_v_q       <= 1'b0;
            digit_nibble_q <= '0;
            seven_enable_q <= 4'b1110;
            frame_done_q   <= 1'b0;
        end else begin
            idx_q          <= idx_d;
            disp_q         <= disp_d;
            pend_q         <= pend_d;
            pend_v_q       <= pend_v_d;
            digit_nibble_q <= digit_nibble_d;
            seven_enable_q <= seven_enable_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign digit_nibble = digit_nibble_q;
    assign seven_enable = seven_enable_q;
    assign frame_done   = frame_done_q;

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000, which sets the number of clk cycles per digit slot; the legal range is 2 to 2^20.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port value, input, 16 bits: four hex digits; digit 0 is value[3:0] and digit 3 is value[15:12].
REQ-005 The block SHALL have port load, input, 1 bit: a one-cycle strobe that captures value as pending.
REQ-006 The block SHALL have port blank_lz, input, 1 bit: the leading-zero blanking enable.
REQ-007 The block SHALL have port digit_nibble, output, 4 bits: the hex code of the active digit, fed to the seven-segment decoder.
REQ-008 The block SHALL have port seven_enable, output, 4 bits: the anode enables, active-low, one-cold or all-high.
REQ-009 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse at each frame wrap.

Function
REQ-010 The block SHALL register all outputs, with no combinational path from inputs to outputs.
REQ-011 The prescaler SHALL count tick_cnt from 0 to TICK_DIV-1 and then wrap to 0.
- A tick is the cycle in which tick_cnt equals TICK_DIV-1.
REQ-012 On each tick, the digit index idx SHALL advance 0→1→2→3→0.
- digit_nibble and seven_enable SHALL update on the same edge, reflecting the new idx.
REQ-013 For a non-blanked slot, seven_enable SHALL equal ~(4'b0001 << idx), and digit_nibble SHALL equal disp[4*idx+3 : 4*idx].
REQ-014 The shadow register disp SHALL drive the display; value SHALL never drive the display directly.
REQ-015 When load=1, pend SHALL be set to value and pend_v SHALL be set to 1.
- A later load before commit SHALL overwrite pend (last write wins).
REQ-016 Commit SHALL occur only on the tick where idx wraps from 3 to 0: if pend_v=1, then disp is set to pend and pend_v is cleared.
- The digit-0 slot starting on that edge SHALL already show the new disp, so no frame ever mixes two values.
REQ-017 If load coincides with the wrap tick, the block SHALL commit the incoming value directly to disp and leave pend_v at 0.
REQ-018 frame_done SHALL be 1 for exactly the one cycle following the 3→0 wrap edge, and 0 otherwise.
REQ-019 Blanking: digit i (i = 1 to 3) SHALL be blanked when blank_lz=1 and disp[15 : 4*i] is 0.
- Digit 0 SHALL never be blanked.
REQ-020 In a blanked slot, seven_enable SHALL be 4'b1111 and digit_nibble SHALL still carry the nibble.
- The slot duration SHALL be unchanged.
REQ-021 blank_lz SHALL be sampled at each tick, taking effect at slot granularity.
REQ-022 The maximum latency from load to visible SHALL be 4·TICK_DIV+1 cycles.

Reset
REQ-023 While rst_n=0, the block SHALL set: tick_cnt=0, idx=0, disp=16'h0000, pend=0, pend_v=0, digit_nibble=4'h0, seven_enable=4'b1110, frame_done=0.
REQ-024 Reset assertion SHALL take effect immediately, without a clock.
- A pending load in progress SHALL be discarded.
REQ-025 After reset release, the first tick SHALL occur TICK_DIV cycles later, and idx SHALL then move to 1.

Structure
REQ-026 The shared package display_pkg SHALL hold: DIGITS=4, NIBBLE_W=4, TICK_DIV_DEFAULT=100000, and the all-off enable constant 4'b1111.
REQ-027 The prescaler SHALL be a sub-module scan_tick, with parameter TICK_DIV, inputs clk and rst_n, and output tick.
REQ-028 display_scan SHALL contain only the index/commit state and the output registers.

Verification (benches run with TICK_DIV=4)
REQ-029 Reset then idle: seven_enable SHALL be 1110, 1101, 1011, 0111, 1110, with each step every 4 cycles; digit_nibble SHALL be 0 throughout.
REQ-030 load with value=16'h1A2F at idx=1: the display SHALL stay 0000 until the 3→0 wrap.
- After the wrap, the nibbles SHALL read F, 2, A, 1, and frame_done SHALL pulse once at the wrap.
REQ-031 Two loads, 16'h1111 then 16'h2222, within one frame: only 2222 SHALL ever be displayed.
REQ-032 load of 16'h00B7 on the exact wrap tick: digit 0 SHALL show 7 in the next slot, and pend_v SHALL stay 0.
REQ-033 blank_lz=1 with disp=16'h0005: enables SHALL be 1110, 1111, 1111, 1111.
- With disp=16'h0000, digit 0 SHALL still be enabled and show 0.
REQ-034 rst_n dropped mid-slot at idx=2 with pend_v=1: outputs SHALL return to the reset values asynchronously.
- The pending value SHALL never be displayed.
